// File: rtl/ext_pkg.sv
// Shared types and constants for the immediate-extension datapath.
package ext_pkg;

  typedef enum logic [1:0] {
    EXT_ZERO      = 2'd0,
    EXT_SIGN      = 2'd1,
    EXT_SIGN_SHL2 = 2'd2,
    EXT_UPPER     = 2'd3
  } ext_mode_t;

  localparam int UPPER_SHIFT = 16;
  localparam int SHL2_SHIFT  = 2;

endpackage

// File: rtl/ext_core.sv
// Combinational field-to-word extension: takes an already-masked field and
// its length, and produces the extended word plus truncation/error flags.
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_BITS  = 26,
  parameter int REG_BITS = 32,
  parameter int LEN_BITS = $clog2(IN_BITS + 1)
) (
  input  logic [IN_BITS-1:0]  i_field,
  input  logic [LEN_BITS-1:0] i_len,
  input  logic                i_sign,
  input  ext_mode_t           i_mode,
  input  logic                i_err,
  output logic [REG_BITS-1:0] o_data,
  output logic                o_trunc,
  output logic                o_err
);

  logic [REG_BITS-1:0] w_ext;
  logic [REG_BITS-1:0] w_len_mask;
  logic [REG_BITS-1:0] w_sext;

  assign w_ext      = {{(REG_BITS-IN_BITS){1'b0}}, i_field};
  assign w_len_mask = ~({REG_BITS{1'b1}} << i_len);
  assign w_sext     = w_ext | (i_sign ? ~w_len_mask : '0);

  always_comb begin
    o_data  = '0;
    o_trunc = 1'b0;
    o_err   = i_err;
    if (!i_err) begin
      case (i_mode)
        EXT_ZERO:      o_data = w_ext;
        EXT_SIGN:      o_data = w_sext;
        EXT_SIGN_SHL2: o_data = w_sext << SHL2_SHIFT;
        EXT_UPPER: begin
          o_data  = w_ext << UPPER_SHIFT;
          // Any set field bit that lands above the word after the shift is lost.
          o_trunc = |(i_field >> (REG_BITS - UPPER_SHIFT));
        end
        default:       o_data = '0;
      endcase
    end
  end

endmodule

// File: rtl/ext_unit_pipe.sv
// Two-stage pipelined immediate-extension unit: stage 1 masks and captures
// the request, stage 2 captures the extended result from ext_core.
module ext_unit_pipe
  import ext_pkg::*;
#(
  parameter int IN_BITS  = 26,
  parameter int REG_BITS = 32,
  parameter int LEN_BITS = $clog2(IN_BITS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_imm,
  input  logic [LEN_BITS-1:0] field_len,
  input  logic [1:0]          mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [REG_BITS-1:0] out_data,
  output logic                out_trunc,
  output logic                out_err
);

  localparam logic [LEN_BITS-1:0] MAX_LEN = LEN_BITS'(IN_BITS);

  logic [LEN_BITS-1:0] w_len_m1;
  logic [IN_BITS-1:0]  w_mask;
  logic [IN_BITS-1:0]  w_sign_pick;
  logic                w_sign;
  logic                w_len_err;
  logic                w_s1_adv;
  logic                w_in_fire;
  logic [REG_BITS-1:0] w_data;
  logic                w_trunc;
  logic                w_err;

  logic                r_s1_valid;
  logic [IN_BITS-1:0]  r_s1_field;
  logic [LEN_BITS-1:0] r_s1_len;
  logic                r_s1_sign;
  logic                r_s1_err;
  ext_mode_t           r_s1_mode;

  logic                r_s2_valid;
  logic [REG_BITS-1:0] r_s2_data;
  logic                r_s2_trunc;
  logic                r_s2_err;

  // A zero length wraps w_len_m1 past the bus, so the sign pick becomes 0.
  assign w_len_m1    = field_len - LEN_BITS'(1);
  assign w_mask      = ~({IN_BITS{1'b1}} << field_len);
  assign w_sign_pick = {{(IN_BITS-1){1'b0}}, 1'b1} << w_len_m1;
  assign w_sign      = |(in_imm & w_sign_pick);
  assign w_len_err   = (field_len == '0) || (field_len > MAX_LEN);

  // valid/ready: a transfer happens on any rising edge where both are high;
  // in_ready depends only on pipeline state and downstream ready, never on in_valid.
  assign w_s1_adv  = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready  = rst_n && (!r_s1_valid || w_s1_adv);
  assign w_in_fire = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_field <= '0;
      r_s1_len   <= '0;
      r_s1_sign  <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_mode  <= EXT_ZERO;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_field <= in_imm & w_mask;
      r_s1_len   <= field_len;
      r_s1_sign  <= w_sign;
      r_s1_err   <= w_len_err;
      r_s1_mode  <= ext_mode_t'(mode);
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  ext_core #(
    .IN_BITS  (IN_BITS),
    .REG_BITS (REG_BITS),
    .LEN_BITS (LEN_BITS)
  ) u_core (
    .i_field (r_s1_field),
    .i_len   (r_s1_len),
    .i_sign  (r_s1_sign),
    .i_mode  (r_s1_mode),
    .i_err   (r_s1_err),
    .o_data  (w_data),
    .o_trunc (w_trunc),
    .o_err   (w_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_trunc <= 1'b0;
      r_s2_err   <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_s2_data  <= w_data;
      r_s2_trunc <= w_trunc;
      r_s2_err   <= w_err;
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_trunc = r_s2_trunc;
  assign out_err   = r_s2_err;

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Directed bench for ext_unit_pipe with a queue-based scoreboard and an
// independent output monitor.
module tb_ext_unit_pipe;

  localparam int IN_BITS  = 26;
  localparam int REG_BITS = 32;
  localparam int LEN_BITS = 5;
  localparam int EW       = REG_BITS + 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [IN_BITS-1:0]  in_imm = '0;
  logic [LEN_BITS-1:0] field_len = '0;
  logic [1:0]          mode = 2'd0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [REG_BITS-1:0] out_data;
  logic                out_trunc;
  logic                out_err;

  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  bit            chk_lat = 1'b0;
  bit            holding = 1'b0;
  logic [EW-1:0] held = '0;

  ext_unit_pipe #(
    .IN_BITS  (IN_BITS),
    .REG_BITS (REG_BITS),
    .LEN_BITS (LEN_BITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .field_len (field_len),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_trunc (out_trunc),
    .out_err   (out_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  function automatic logic [EW-1:0] mk(input logic [REG_BITS-1:0] d, input logic t, input logic e);
    return {e, t, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [IN_BITS-1:0] imm, input logic [LEN_BITS-1:0] len,
                      input logic [1:0] md, input logic [EW-1:0] exp);
    int waits = 0;
    in_valid  = 1'b1;
    in_imm    = imm;
    field_len = len;
    mode      = md;
    @(negedge clk);
    while (!in_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for imm %h", imm);
    end else begin
      exp_q.push_back(exp);
      acc_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      holding = 1'b0;
    end else begin
      if (holding && out_valid)
        chk("stall_hold", {30'd0, out_err, out_trunc, out_data}, {30'd0, held});
      holding = out_valid && !out_ready;
      held    = {out_err, out_trunc, out_data};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %h with empty expected queue", out_data);
        end else begin
          logic [EW-1:0] e;
          int a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("result", {30'd0, out_err, out_trunc, out_data}, {30'd0, e});
          if (chk_lat) chk("latency", 64'(cyc + 1 - a), 64'd2);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int waits;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data",  {32'd0, out_data},  64'd0);
    chk("rst_out_flags", {62'd0, out_trunc, out_err}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Fixed 26->32 sign-extension equivalence, back-to-back with latency check
    chk_lat = 1'b1;
    send(26'h0000001, 5'd26, 2'd1, mk(32'h00000001, 1'b0, 1'b0));
    send(26'h3FFFFFF, 5'd26, 2'd1, mk(32'hFFFFFFFF, 1'b0, 1'b0));
    send(26'h1FFFFFF, 5'd26, 2'd1, mk(32'h01FFFFFF, 1'b0, 1'b0));

    // Mode sweep with garbage above field_len
    send(26'h3FF8000, 5'd16, 2'd0, mk(32'h00008000, 1'b0, 1'b0));
    send(26'h3FF8000, 5'd16, 2'd1, mk(32'hFFFF8000, 1'b0, 1'b0));
    send(26'h3FF8000, 5'd16, 2'd2, mk(32'hFFFE0000, 1'b0, 1'b0));
    send(26'h3FF8000, 5'd16, 2'd3, mk(32'h80000000, 1'b0, 1'b0));

    // Truncation in UPPER mode
    send(26'h00F1234, 5'd20, 2'd3, mk(32'h12340000, 1'b1, 1'b0));
    send(26'h00F1234, 5'd16, 2'd3, mk(32'h12340000, 1'b0, 1'b0));

    // Error lengths and boundary lengths
    send(26'h3FFFFFF, 5'd0,  2'd1, mk(32'h00000000, 1'b0, 1'b1));
    send(26'h3FFFFFF, 5'd27, 2'd3, mk(32'h00000000, 1'b0, 1'b1));
    send(26'h0000001, 5'd1,  2'd1, mk(32'hFFFFFFFF, 1'b0, 1'b0));
    send(26'h3FFFFFF, 5'd26, 2'd0, mk(32'h03FFFFFF, 1'b0, 1'b0));
    send(26'h2000000, 5'd26, 2'd2, mk(32'hF8000000, 1'b0, 1'b0));
    repeat (3) @(posedge clk);
    #1;
    chk_lat = 1'b0;

    // Backpressure: four requests against a 5-cycle stall
    out_ready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 4; k++)
          send(26'(k), 5'd8, 2'd0, mk(32'(k), 1'b0, 1'b0));
      end
      begin
        for (int i = 0; i <= 8; i++) begin
          @(negedge clk);
          if (i == 2) chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
          if (i >= 2 && i <= 4) chk("bp_hold_data", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'd1});
          if (i >= 5) chk("bp_drain", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'(i - 4)});
          if (i == 4) begin
            @(posedge clk);
            #1;
            out_ready = 1'b1;
          end
        end
      end
    join
    @(posedge clk);
    #1;

    // Reset mid-stream with both stages full and a request offered at the reset edge
    out_ready = 1'b0;
    send(26'h0000AAA, 5'd12, 2'd0, mk(32'h00000AAA, 1'b0, 1'b0));
    send(26'h0000BBB, 5'd12, 2'd0, mk(32'h00000BBB, 1'b0, 1'b0));
    chk("full_before_rst", {62'd0, out_valid, in_ready}, {62'd0, 1'b1, 1'b0});
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_imm    = 26'h0000CCC;
    field_len = 5'd12;
    mode      = 2'd0;
    @(negedge clk);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_out_data",  {32'd0, out_data},  64'd0);
    chk("midrst_in_ready2", {63'd0, in_ready},  64'd0);
    exp_q.delete();
    acc_q.delete();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("after_rst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (4) @(negedge clk);
    chk("no_stale_output", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    send(26'h0000123, 5'd12, 2'd0, mk(32'h00000123, 1'b0, 1'b0));

    // Drain
    waits = 0;
    while (exp_q.size() != 0 && waits < 100) begin
      waits++;
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ext_unit_pipe.md
Name: ext_unit_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the datapath. Successor to the fixed 26→32 sign extender.
- Takes an immediate field of runtime-selectable length and applies one of four extension modes: zero, sign, sign-shift-left-2 (branch offset) or upper (shift left 16).
- Two-stage registered pipeline with valid/ready handshake on both sides.
- Flags malformed requests and lost upper bits.

Parameters:
- IN_BITS, 26, width of the in_imm bus; maximum field length.
- REG_BITS, 32, output word width; must be >= IN_BITS+2.
- LEN_BITS, $clog2(IN_BITS+1), width of the field_len input.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  unit accepts request this cycle.
- in_imm  input  IN_BITS  raw immediate; bits at and above field_len are ignored.
- field_len  input  LEN_BITS  number of valid low bits of in_imm, range 1..IN_BITS.
- mode  input  2  0=ZERO, 1=SIGN, 2=SIGN_SHL2, 3=UPPER.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out_data  output  REG_BITS  extended value.
- out_trunc  output  1  nonzero field bits were discarded (UPPER mode only).
- out_err  output  1  field_len was 0 or greater than IN_BITS.

Behaviour:
- Reset: synchronous, active-low. On a clock edge with rst_n=0, both stage valids clear.
  - out_valid=0, out_data=0, out_trunc=0, out_err=0.
  - in_ready is forced to 0 while rst_n=0.
  - Reset mid-stream discards all in-flight requests. No partial result appears afterwards.
- Handshake: a transfer occurs on any edge where valid&&ready.
  - in_ready = !s1_valid || (s1 moves to s2 this cycle).
  - s1 moves to s2 when !s2_valid || out_ready.
  - out_data, out_trunc and out_err stay stable while out_valid && !out_ready.
  - in_ready must not depend combinationally on in_valid.
- Stage 1: registers in_imm masked to field_len bits (upper bits forced to 0), plus mode.
  - Also registers sign = in_imm[field_len-1] and err = (field_len==0 || field_len>IN_BITS).
- Stage 2: computes the result from the masked field f, of length L:
  - ZERO: out = f zero-extended.
  - SIGN: out = f with bits [REG_BITS-1:L] = sign.
  - SIGN_SHL2: out = (SIGN result) << 2; the low two bits are 0.
  - UPPER: out = f << 16, truncated to REG_BITS. out_trunc=1 iff any f bit at position >= REG_BITS-16 is 1.
  - err=1: out_data=0, out_trunc=0, out_err=1. The mode is ignored.
- Latency and throughput:
  - Latency is exactly 2 cycles from input handshake to out_valid when out_ready stays high.
  - Sustained throughput is 1 result per cycle.
- Ordering and capacity: results leave in acceptance order. There is no drop and no duplication under any out_ready pattern.
  - With out_ready held low, the unit holds at most 2 requests. in_ready then goes low the cycle after the 2nd acceptance.
- Simultaneous events:
  - s2 drains and s1 refills on the same edge: both happen, and throughput is preserved.
  - Input handshake on the same edge as reset: the request is discarded.
- Boundary lengths:
  - field_len=IN_BITS uses the full bus.
  - field_len=1: SIGN of 1'b1 gives all ones.

Decomposition:
- Shared package ext_pkg:
  - typedef ext_mode_t (2-bit enum EXT_ZERO, EXT_SIGN, EXT_SIGN_SHL2, EXT_UPPER).
  - Constant UPPER_SHIFT=16.
  - Constant SHL2_SHIFT=2.
- Sub-module ext_core: purely combinational field→word extension, parametrised by IN_BITS and REG_BITS.
  - Produces data, trunc and err.
  - Instantiated once, between the stage-1 and stage-2 registers.
- The top holds the pipeline registers and the handshake logic.

Test Plan (IN_BITS=26, REG_BITS=32 unless stated):
- Fixed-generation equivalence, mode=SIGN, field_len=26, out_ready=1:
  - in_imm 26'h0000001 → 32'h00000001.
  - in_imm 26'h3FFFFFF → 32'hFFFFFFFF.
  - in_imm 26'h1FFFFFF → 32'h01FFFFFF.
  - Each result arrives exactly 2 cycles after acceptance, back-to-back.
- Mode sweep, field_len=16, in_imm=26'h3FF8000 (the upper bits must be ignored):
  - ZERO → 32'h00008000.
  - SIGN → 32'hFFFF8000.
  - SIGN_SHL2 → 32'hFFFE0000.
  - UPPER → 32'h80000000 with out_trunc=0.
- Truncation, UPPER, field_len=20, in_imm=26'h00F1234 → out_data=32'h12340000, out_trunc=1.
  - Same request with field_len=16 → out_trunc=0.
- Error lengths:
  - field_len=0 → out_data=0, out_err=1.
  - field_len=27 → out_data=0, out_err=1.
  - field_len=1 with in_imm bit0=1, SIGN → 32'hFFFFFFFF, out_err=0.
- Backpressure: offer 4 consecutive requests (values 1,2,3,4, ZERO mode) with out_ready=0 for 5 cycles, then 1.
  - in_ready=0 after 2 acceptances.
  - out_data holds 1 while stalled.
  - Outputs then appear 1,2,3,4 in order with no gaps once drained.
- Reset mid-stream: assert rst_n=0 for 1 cycle while both stages are full.
  - Next cycle: out_valid=0 and in_ready=0 during reset.
  - After reset releases, in_ready=1 and no stale result is ever emitted.
